mips_muldiv_ctrl: RTL
=====================

// Module: mips_muldiv_ctrl
// PURPOSE
//  Iterative multiply/divide sequencer owning the HI/LO register pair.
//  Executes MULT, MULTU, DIV and DIVU over multiple cycles and services MTHI/MTLO writes.
//  Stalls the core when a HI/LO access conflicts with an operation in flight.
//  Sits beside the ALU in the execute stage; decode supplies start/op, the register file supplies rs/rt.
// PARAMETERS
//  WIDTH    32            operand, HI and LO width
//  DIV0_LO  32'hFFFF_FFFF LO value written on divide-by-zero; HI gets the dividend
// PORTS
//  clk       in   1      single clock; all state updates on its rising edge
//  rst       in   1      asynchronous reset, active-high
//  start     in   1      request a mul/div this cycle
//  op        in   2      0=MULT 1=MULTU 2=DIV 3=DIVU (sampled with start)
//  rs_data   in   WIDTH  multiplicand / dividend
//  rt_data   in   WIDTH  multiplier / divisor
//  mthi      in   1      write rs_data to HI
//  mtlo      in   1      write rs_data to LO
//  mf_req    in   1      MFHI/MFLO in decode wants HI/LO this cycle
//  kill      in   1      abort in-flight operation (exception/flush)
//  hi        out  WIDTH  HI register
//  lo        out  WIDTH  LO register
//  busy      out  1      operation in flight
//  stall     out  1      core must hold the current instruction
// BEHAVIOUR
//  Reset: state=IDLE; hi=0, lo=0, busy=0, stall=0; counter and working registers cleared, also mid-operation.
//  FSM states:
//   IDLE -> CALC on start & ~kill: latch op, sign flags, |rs|, |rt| (signed ops only), count=WIDTH-1.
//   CALC: one radix-2 step per cycle (shift-add multiply, restoring divide). When count==0 -> FIX, else count-1.
//   FIX: apply signs, write hi/lo, -> IDLE.
//  Latency: start at edge N; hi/lo hold the result after edge N+WIDTH+1; busy high for WIDTH+1 cycles.
//  busy = (state != IDLE); stall = busy & (start | mthi | mtlo | mf_req), combinational.
//  A start, mthi or mtlo while busy is ignored and stalls; the core re-presents it when busy drops.
//  mthi/mtlo in IDLE update hi/lo at the next edge. mthi/mtlo with start in the same IDLE cycle: the
//  start wins and the moves are dropped (the decoder never issues both).
//  MULT/MULTU: {hi,lo} = 2*WIDTH-bit product; MULT negates it when the operand signs differ.
//  DIV/DIVU: lo=quotient, hi=remainder; signed quotient is negative when signs differ; remainder takes dividend sign.
//  Divide-by-zero (rt==0, DIV/DIVU): skip CALC; FIX writes lo=DIV0_LO, hi=rs_data; busy for 1 cycle.
//  Signed 0x8000_0000 / -1: lo=0x8000_0000, hi=0, with no trap.
//  kill: any state -> IDLE next edge; hi/lo unchanged; kill in IDLE blocks a same-cycle start.
//  hi/lo change only in FIX, on mthi/mtlo in IDLE, or on reset.
// STRUCTURE
//  Package mips_muldiv_pkg: muldiv_op_t enum {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}, md_state_t {IDLE, CALC, FIX}, op encodings.
//  Sub-module mips_muldiv_step (combinational): one shift-add or restore-subtract step on {acc, q}. The FSM, counter and sign fix stay in the top.
// TESTING
//  MULTU 0xFFFF_FFFF*0xFFFF_FFFF -> after 33 busy cycles hi=0xFFFF_FFFE, lo=0x0000_0001.
//  MULT -3*7 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFEB; DIV -7/2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
//  DIVU 100/0 -> busy 1 cycle, lo=0xFFFF_FFFF, hi=100; DIV 0x8000_0000/-1 -> lo=0x8000_0000, hi=0.
//  mf_req, mthi and a second start during CALC -> stall=1 each cycle, hi/lo unchanged until FIX.
//  kill at CALC cycle 10 -> IDLE next edge, hi/lo keep prior values; assert rst mid-CALC -> hi=lo=0, busy=0 immediately.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg: shared op encodings and FSM state type for the mul/div sequencer
package mips_muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/mips_muldiv_step.sv
// mips_muldiv_step: one radix-2 shift-add multiply or restoring-divide step on {acc, q}
module mips_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] acc_n,
    output logic [WIDTH-1:0] q_n
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem;
    logic [WIDTH:0] diff;

    // Multiply adds m when the multiplier LSB is set and shifts right; divide shifts left and keeps the difference when it does not borrow
    always_comb begin
        sum   = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
        rem   = {acc, q[WIDTH-1]};
        diff  = rem - {1'b0, m};
        acc_n = is_div ? (diff[WIDTH] ? rem[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
        q_n   = is_div ? {q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], q[WIDTH-1:1]};
    end

endmodule

// File: rtl/mips_muldiv_ctrl.sv
// mips_muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with core stall generation
module mips_muldiv_ctrl
    import mips_muldiv_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             mf_req,
    input  logic             kill,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          state, state_n;
    muldiv_op_t         op_r;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   acc, q, m;
    logic [WIDTH-1:0]   acc_n, q_n;
    logic               sa, sb, div0;
    logic               in_signed, in_div0, is_div;
    logic [WIDTH-1:0]   abs_rs, abs_rt;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign in_signed = ~op[0];
    assign in_div0   = op[1] & (rt_data == '0);
    assign abs_rs    = (in_signed & rs_data[WIDTH-1]) ? -rs_data : rs_data;
    assign abs_rt    = (in_signed & rt_data[WIDTH-1]) ? -rt_data : rt_data;
    assign is_div    = (op_r == MD_DIV) || (op_r == MD_DIVU);
    assign prod_fix  = (sa ^ sb) ? -{acc, q} : {acc, q};
    assign quo_fix   = (sa ^ sb) ? -q : q;
    assign rem_fix   = sa ? -acc : acc;
    assign busy      = (state != IDLE);
    assign stall     = busy & (start | mthi | mtlo | mf_req);

    mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div),
        .acc    (acc),
        .q      (q),
        .m      (m),
        .acc_n  (acc_n),
        .q_n    (q_n)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state: divide-by-zero bypasses CALC, kill always returns to IDLE
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = in_div0 ? FIX : CALC;
            CALC:    if (count == '0) state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (kill) state_n = IDLE;
    end

    // Operand capture, iteration, sign fix-up and HI/LO writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r  <= MD_MULT;
            count <= '0;
            acc   <= '0;
            q     <= '0;
            m     <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            div0  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else if (!kill) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r  <= muldiv_op_t'(op);
                        sa    <= in_signed & rs_data[WIDTH-1];
                        sb    <= in_signed & rt_data[WIDTH-1];
                        div0  <= in_div0;
                        acc   <= '0;
                        q     <= in_div0 ? rs_data : abs_rs;
                        m     <= abs_rt;
                        count <= CW'(WIDTH - 1);
                    end else begin
                        if (mthi) hi <= rs_data;
                        if (mtlo) lo <= rs_data;
                    end
                end
                CALC: begin
                    acc   <= acc_n;
                    q     <= q_n;
                    count <= count - 1'b1;
                end
                FIX: begin
                    hi <= div0 ? q : (is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH]);
                    lo <= div0 ? DIV0_LO : (is_div ? quo_fix : prod_fix[WIDTH-1:0]);
                end
                default: ;
            endcase
        end
    end

endmodule
